// File: rtl/bsh_pkg.sv
// ---------------------------------------------------------------------------
// bsh_pkg: shared types and helpers for pipelined_barrel_shifter.
//   bsh_mode_e    operation encoding carried on the 3-bit mode bus
//                 (5..7 are reserved and pass data through unchanged).
//   bsh_is_right  1 for the operations that move bits towards bit 0.
//   bsh_log2      stage count for a power-of-two data width.
// Optional feature macro used by the design files: BSH_FLAGS_EN.
// ---------------------------------------------------------------------------
package bsh_pkg;

  typedef enum logic [2:0] {
    BSH_SHL = 3'd0,
    BSH_SHR = 3'd1,
    BSH_SAR = 3'd2,
    BSH_ROL = 3'd3,
    BSH_ROR = 3'd4
  } bsh_mode_e;

  function automatic logic bsh_is_right(input logic [2:0] mode);
    return (mode == BSH_SHR) || (mode == BSH_SAR) || (mode == BSH_ROR);
  endfunction

  function automatic int bsh_log2(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/bsh_stage.sv
// ---------------------------------------------------------------------------
// bsh_stage: one mux level of the barrel shifter. Shifts/rotates by
// 2**STAGE_IDX when in_amt[STAGE_IDX] is set, otherwise passes data through.
// With REG = 1 the result is held in an elastic valid/ready register slot;
// with REG = 0 the stage is purely combinational and handshakes pass through.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   in_valid/in_ready             upstream handshake
//   in_data/in_mode/in_amt        beat from the previous stage
//   out_valid/out_ready           downstream handshake
//   out_data/out_mode/out_amt     beat towards the next stage
//   in_carry/out_carry            running carry flag (only with BSH_FLAGS_EN)
// ---------------------------------------------------------------------------
module bsh_stage
  import bsh_pkg::*;
#(
  parameter int N         = 8,
  parameter int STAGE_IDX = 0,
  parameter int AW        = 3,
  parameter bit REG       = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_data,
  input  logic [2:0]    in_mode,
  input  logic [AW-1:0] in_amt,
`ifdef BSH_FLAGS_EN
  input  logic          in_carry,
  output logic          out_carry,
`endif
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_data,
  output logic [2:0]    out_mode,
  output logic [AW-1:0] out_amt
);

  localparam int SH = 1 << STAGE_IDX;

  logic [N-1:0] mux_data;

  always_comb begin
    mux_data = in_data;
    if (in_amt[STAGE_IDX]) begin
      case (in_mode)
        BSH_SHL: mux_data = in_data << SH;
        BSH_SHR: mux_data = in_data >> SH;
        // Earlier stages keep the MSB for SAR, so it is still the sign.
        BSH_SAR: mux_data = $signed(in_data) >>> SH;
        BSH_ROL: mux_data = (in_data << SH) | (in_data >> (N - SH));
        BSH_ROR: mux_data = (in_data >> SH) | (in_data << (N - SH));
        default: mux_data = in_data;
      endcase
    end
  end

`ifdef BSH_FLAGS_EN
  // The last stage that actually moves bits decides the carry. Indices are
  // taken relative to this stage's input, which already carries the shifts
  // of the lower stages, so they resolve to data_in[N-amt] / data_in[amt-1].
  logic mux_carry;

  always_comb begin
    mux_carry = in_carry;
    if (in_amt[STAGE_IDX]) begin
      case (in_mode)
        BSH_SHL, BSH_SHR, BSH_SAR:
          mux_carry = bsh_is_right(in_mode) ? in_data[SH-1] : in_data[N-SH];
        BSH_ROL: mux_carry = in_data[N-SH];  // bit landing in position 0
        BSH_ROR: mux_carry = in_data[SH-1];  // bit landing in position N-1
        default: mux_carry = in_carry;
      endcase
    end
  end
`endif

  if (REG) begin : g_reg
    logic          valid_reg;
    logic [N-1:0]  data_reg;
    logic [2:0]    mode_reg;
    logic [AW-1:0] amt_reg;
`ifdef BSH_FLAGS_EN
    logic          carry_reg;
`endif

    // Slot takes a new beat when empty or when its content leaves this cycle.
    assign in_ready = !valid_reg || out_ready;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        valid_reg <= 1'b0;
        data_reg  <= '0;
        mode_reg  <= '0;
        amt_reg   <= '0;
`ifdef BSH_FLAGS_EN
        carry_reg <= 1'b0;
`endif
      end else if (in_ready) begin
        valid_reg <= in_valid;
        if (in_valid) begin
          data_reg  <= mux_data;
          mode_reg  <= in_mode;
          amt_reg   <= in_amt;
`ifdef BSH_FLAGS_EN
          carry_reg <= mux_carry;
`endif
        end
      end
    end

    assign out_valid = valid_reg;
    assign out_data  = data_reg;
    assign out_mode  = mode_reg;
    assign out_amt   = amt_reg;
`ifdef BSH_FLAGS_EN
    assign out_carry = carry_reg;
`endif
  end else begin : g_comb
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;

    assign in_ready  = out_ready;
    assign out_valid = in_valid;
    assign out_data  = mux_data;
    assign out_mode  = in_mode;
    assign out_amt   = in_amt;
`ifdef BSH_FLAGS_EN
    assign out_carry = mux_carry;
`endif
  end

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// ---------------------------------------------------------------------------
// pipelined_barrel_shifter: SHL/SHR/SAR/ROL/ROR barrel shifter built from
// log2(N) bsh_stage mux levels with valid/ready on both sides.
// PIPELINED != 0 registers every level (latency log2(N)); PIPELINED == 0
// keeps the levels combinational and registers only the last (latency 1).
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   in_valid/in_ready     input handshake
//   data_in               operand
//   shift_amt             shift/rotate amount 0..N-1
//   mode                  bsh_mode_e encoding; 5..7 pass data_in through
//   out_valid/out_ready   output handshake
//   data_out              result
//   zero_out, carry_out   result flags, present only with BSH_FLAGS_EN
// ---------------------------------------------------------------------------
module pipelined_barrel_shifter
  import bsh_pkg::*;
#(
  parameter int N         = 8,
  parameter int PIPELINED = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N-1:0]         data_in,
  input  logic [$clog2(N)-1:0] shift_amt,
  input  logic [2:0]           mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N-1:0]         data_out
`ifdef BSH_FLAGS_EN
  ,
  output logic                 zero_out,
  output logic                 carry_out
`endif
);

  localparam int LOG2N = bsh_log2(N);

  // Index k is the input of level k; index LOG2N is the block output.
  logic [LOG2N:0]   valid_chain;
  logic [LOG2N:0]   ready_chain;
  logic [N-1:0]     data_chain [0:LOG2N];
  logic [2:0]       mode_chain [0:LOG2N];
  logic [LOG2N-1:0] amt_chain  [0:LOG2N];
`ifdef BSH_FLAGS_EN
  logic [LOG2N:0]   carry_chain;
  assign carry_chain[0] = 1'b0;
`endif

  assign valid_chain[0]     = in_valid;
  assign in_ready           = ready_chain[0];
  assign data_chain[0]      = data_in;
  assign mode_chain[0]      = mode;
  assign amt_chain[0]       = shift_amt;
  assign ready_chain[LOG2N] = out_ready;

  for (genvar gi = 0; gi < LOG2N; gi++) begin : g_stage
    bsh_stage #(
      .N         (N),
      .STAGE_IDX (gi),
      .AW        (LOG2N),
      .REG       ((PIPELINED != 0) || (gi == LOG2N - 1))
    ) u_stage (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (valid_chain[gi]),
      .in_ready  (ready_chain[gi]),
      .in_data   (data_chain[gi]),
      .in_mode   (mode_chain[gi]),
      .in_amt    (amt_chain[gi]),
`ifdef BSH_FLAGS_EN
      .in_carry  (carry_chain[gi]),
      .out_carry (carry_chain[gi+1]),
`endif
      .out_valid (valid_chain[gi+1]),
      .out_ready (ready_chain[gi+1]),
      .out_data  (data_chain[gi+1]),
      .out_mode  (mode_chain[gi+1]),
      .out_amt   (amt_chain[gi+1])
    );
  end

  assign out_valid = valid_chain[LOG2N];
  assign data_out  = data_chain[LOG2N];

  // Mode/amount only steer the levels; nothing consumes them at the output.
  logic unused_tail;
  assign unused_tail = ^{mode_chain[LOG2N], amt_chain[LOG2N]};

`ifdef BSH_FLAGS_EN
  // Qualified by out_valid so the flag is 0 out of reset and with no result.
  assign zero_out  = out_valid && (data_out == '0);
  assign carry_out = carry_chain[LOG2N];
`endif

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// ---------------------------------------------------------------------------
// tb_pipelined_barrel_shifter: drives a PIPELINED=1 instance (index 0) and a
// PIPELINED=0 instance (index 1) with N = 8. A per-instance scoreboard
// compares every output transfer with a reference model computed bit by bit
// from the operation definitions. Flag checks are active with BSH_FLAGS_EN.
// ---------------------------------------------------------------------------
module tb_pipelined_barrel_shifter;
  import bsh_pkg::*;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid  [2];
  logic         in_ready  [2];
  logic         out_valid [2];
  logic         out_ready [2];
  logic [N-1:0] data_in   [2];
  logic [N-1:0] data_out  [2];
  logic [2:0]   amt       [2];
  logic [2:0]   mode      [2];
`ifdef BSH_FLAGS_EN
  logic         zero_flag  [2];
  logic         carry_flag [2];
`endif
  bit           lat_chk   [2];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pipelined_barrel_shifter #(.N(N), .PIPELINED(1)) u_dut_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid[0]),
    .in_ready  (in_ready[0]),
    .data_in   (data_in[0]),
    .shift_amt (amt[0]),
    .mode      (mode[0]),
    .out_valid (out_valid[0]),
    .out_ready (out_ready[0]),
    .data_out  (data_out[0])
`ifdef BSH_FLAGS_EN
    ,
    .zero_out  (zero_flag[0]),
    .carry_out (carry_flag[0])
`endif
  );

  pipelined_barrel_shifter #(.N(N), .PIPELINED(0)) u_dut_comb (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid[1]),
    .in_ready  (in_ready[1]),
    .data_in   (data_in[1]),
    .shift_amt (amt[1]),
    .mode      (mode[1]),
    .out_valid (out_valid[1]),
    .out_ready (out_ready[1]),
    .data_out  (data_out[1])
`ifdef BSH_FLAGS_EN
    ,
    .zero_out  (zero_flag[1]),
    .carry_out (carry_flag[1])
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Returns {carry, result}, built one output bit at a time.
  function automatic logic [N:0] ref_model(input logic [N-1:0] d, input int a, input logic [2:0] m);
    logic [N-1:0] r;
    logic         c;
    r = d;
    c = 1'b0;
    if (a != 0) begin
      case (m)
        3'd0: begin for (int j = 0; j < N; j++) r[j] = (j >= a) ? d[j-a] : 1'b0;     c = d[N-a]; end
        3'd1: begin for (int j = 0; j < N; j++) r[j] = (j + a < N) ? d[j+a] : 1'b0;  c = d[a-1]; end
        3'd2: begin for (int j = 0; j < N; j++) r[j] = (j + a < N) ? d[j+a] : d[N-1]; c = d[a-1]; end
        3'd3: begin for (int j = 0; j < N; j++) r[j] = d[(j - a + N) % N];          c = r[0];   end
        3'd4: begin for (int j = 0; j < N; j++) r[j] = d[(j + a) % N];              c = r[N-1]; end
        default: begin r = d; c = 1'b0; end
      endcase
    end
    return {c, r};
  endfunction

  // Scoreboards: sampled on the falling edge, away from the active edge.
  for (genvar gi = 0; gi < 2; gi++) begin : g_sb
    logic [N:0]   exp_q [$];
    int           acc_q [$];
    bit           seen  = 1'b0;
    bit           stall = 1'b0;
    logic [N-1:0] held  = '0;

    always @(negedge clk) begin
      if (rst) begin
        exp_q.delete();
        acc_q.delete();
        seen  = 1'b0;
        stall = 1'b0;
      end else begin
        if (stall)
          check($sformatf("hold%0d", gi), {23'd0, out_valid[gi], data_out[gi]}, {23'd0, 1'b1, held});
        stall = out_valid[gi] && !out_ready[gi];
        held  = data_out[gi];
        if (out_valid[gi]) begin
          if (exp_q.size() == 0) begin
            check($sformatf("spurious%0d", gi), 32'(out_valid[gi]), 32'd0);
          end else begin
            if (!seen) begin
              seen = 1'b1;
              if (lat_chk[gi])
                check($sformatf("latency%0d", gi), 32'(cyc - acc_q[0]), (gi == 0) ? 32'd3 : 32'd1);
            end
            if (out_ready[gi]) begin
              check($sformatf("data%0d", gi), 32'(data_out[gi]), 32'(exp_q[0][N-1:0]));
`ifdef BSH_FLAGS_EN
              check($sformatf("carry%0d", gi), 32'(carry_flag[gi]), 32'(exp_q[0][N]));
              check($sformatf("zero%0d", gi), 32'(zero_flag[gi]), 32'(exp_q[0][N-1:0] == '0));
`endif
              void'(exp_q.pop_front());
              void'(acc_q.pop_front());
              seen = 1'b0;
            end
          end
        end
        if (in_valid[gi] && in_ready[gi]) begin
          exp_q.push_back(ref_model(data_in[gi], int'(amt[gi]), mode[gi]));
          acc_q.push_back(cyc);
        end
      end
    end
  end

  // Called #1 after a rising edge; returns #1 after the accepting edge.
  task automatic send0(input logic [N-1:0] d, input logic [2:0] a, input logic [2:0] m);
    int n = 0;
    in_valid[0] = 1'b1;
    data_in[0]  = d;
    amt[0]      = a;
    mode[0]     = m;
    @(negedge clk);
    while (!in_ready[0] && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready[0]) check("send_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    in_valid[0] = 1'b0;
  endtask

  task automatic wait_out0(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (out_valid[0]) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("out_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain_all();
    int n = 0;
    while ((g_sb[0].exp_q.size() != 0 || g_sb[1].exp_q.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain", 32'(g_sb[0].exp_q.size() + g_sb[1].exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  typedef struct packed {
    logic [7:0] d;
    logic [2:0] a;
    logic [2:0] m;
    logic [7:0] r;
    logic       c;
  } vec_t;

  vec_t vecs [13];

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int nacc;
    int sent [2];
    int tgt  [2];
    bit acc  [2];

    vecs = '{
      '{8'h96, 3'd3, BSH_SHL, 8'hB0, 1'b0},
      '{8'h96, 3'd2, BSH_SAR, 8'hE5, 1'b1},
      '{8'h96, 3'd2, BSH_SHR, 8'h25, 1'b1},
      '{8'h96, 3'd1, BSH_ROR, 8'h4B, 1'b0},
      '{8'h81, 3'd4, BSH_ROL, 8'h18, 1'b0},
      '{8'h01, 3'd7, BSH_ROL, 8'h80, 1'b0},
      '{8'h5A, 3'd5, 3'd6,    8'h5A, 1'b0},
      '{8'hC3, 3'd0, BSH_SHL, 8'hC3, 1'b0},
      '{8'hC3, 3'd0, BSH_SHR, 8'hC3, 1'b0},
      '{8'hC3, 3'd0, BSH_SAR, 8'hC3, 1'b0},
      '{8'hC3, 3'd0, BSH_ROL, 8'hC3, 1'b0},
      '{8'hC3, 3'd0, BSH_ROR, 8'hC3, 1'b0},
      '{8'h80, 3'd1, BSH_SHL, 8'h00, 1'b1}
    };

    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_valid[i]  = 1'b0;
      out_ready[i] = 1'b1;
      data_in[i]   = '0;
      amt[i]       = '0;
      mode[i]      = '0;
      lat_chk[i]   = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("rst_valid%0d", i), 32'(out_valid[i]), 32'd0);
      check($sformatf("rst_data%0d", i), 32'(data_out[i]), 32'd0);
    end
    rst = 1'b0;
    #1;
    for (int i = 0; i < 2; i++)
      check($sformatf("rst_in_ready%0d", i), 32'(in_ready[i]), 32'd1);
    @(posedge clk);
    #1;

    // Directed vectors, one at a time, with constant expected values.
    lat_chk[0] = 1'b1;
    foreach (vecs[k]) begin
      send0(vecs[k].d, vecs[k].a, vecs[k].m);
      wait_out0(ok);
      if (ok) begin
        check($sformatf("vec%0d_data", k), 32'(data_out[0]), 32'(vecs[k].r));
`ifdef BSH_FLAGS_EN
        check($sformatf("vec%0d_carry", k), 32'(carry_flag[0]), 32'(vecs[k].c));
        check($sformatf("vec%0d_zero", k), 32'(zero_flag[0]), 32'(vecs[k].r == 8'h00));
`endif
      end
      @(posedge clk);
      #1;
      $display("vec %0d: d=%02h amt=%0d mode=%0d -> %02h", k, vecs[k].d, vecs[k].a, vecs[k].m, data_out[0]);
    end
    lat_chk[0] = 1'b0;

    // Backpressure: capacity 3, then a stall-free stream of 6 results.
    out_ready[0] = 1'b0;
    nacc = 0;
    for (int k = 0; k < 6; k++) begin
      in_valid[0] = 1'b1;
      data_in[0]  = 8'h10 + 8'(nacc * 37);
      amt[0]      = 3'(nacc + 1);
      mode[0]     = 3'(nacc % 5);
      @(negedge clk);
      if (in_ready[0]) nacc++;
      @(posedge clk);
      #1;
    end
    check("bp_accepted", 32'(nacc), 32'd3);
    check("bp_in_ready_low", 32'(in_ready[0]), 32'd0);
    out_ready[0] = 1'b1;
    for (int k = 0; k < 6; k++) begin
      in_valid[0] = (nacc < 6);
      data_in[0]  = 8'h10 + 8'(nacc * 37);
      amt[0]      = 3'(nacc + 1);
      mode[0]     = 3'(nacc % 5);
      @(negedge clk);
      check($sformatf("bp_stream%0d", k), 32'(out_valid[0]), 32'd1);
      if (in_valid[0] && in_ready[0]) nacc++;
      @(posedge clk);
      #1;
    end
    in_valid[0] = 1'b0;
    check("bp_all_accepted", 32'(nacc), 32'd6);
    drain_all();
    $display("backpressure: %0d beats accepted", nacc);

    // Reset with two beats in flight.
    in_valid[0] = 1'b1;
    data_in[0]  = 8'hA5;
    amt[0]      = 3'd3;
    mode[0]     = BSH_ROL;
    @(posedge clk);
    #1;
    data_in[0]  = 8'h3C;
    @(posedge clk);
    #1;
    in_valid[0] = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("midrst_valid", 32'(out_valid[0]), 32'd0);
    check("midrst_data", 32'(data_out[0]), 32'd0);
`ifdef BSH_FLAGS_EN
    check("midrst_carry", 32'(carry_flag[0]), 32'd0);
`endif
    @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("midrst_no_stale", 32'(out_valid[0]), 32'd0);
    end
    @(posedge clk);
    #1;
    $display("mid-operation reset: pipeline flushed");

    // Random traffic on both instances with random backpressure.
    lat_chk[1]  = 1'b1;
    sent        = '{0, 0};
    tgt         = '{300, 1000};
    in_valid[1] = 1'b1;
    data_in[1]  = 8'h80;
    amt[1]      = 3'd1;
    mode[1]     = BSH_SHL;
    for (int g = 0; g < 20000 && (sent[0] < tgt[0] || sent[1] < tgt[1]); g++) begin
      for (int i = 0; i < 2; i++) begin
        if (!in_valid[i] && sent[i] < tgt[i] && $urandom_range(0, 3) != 0) begin
          in_valid[i] = 1'b1;
          data_in[i]  = 8'($urandom);
          amt[i]      = 3'($urandom_range(0, 7));
          mode[i]     = 3'($urandom_range(0, 7));
        end
        out_ready[i] = ($urandom_range(0, 3) != 0);
      end
      @(negedge clk);
      for (int i = 0; i < 2; i++) acc[i] = in_valid[i] && in_ready[i];
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
        if (acc[i]) begin
          sent[i]++;
          in_valid[i] = 1'b0;
        end
      end
    end
    check("rand_sent_pipe", 32'(sent[0]), 32'(tgt[0]));
    check("rand_sent_comb", 32'(sent[1]), 32'(tgt[1]));
    out_ready[0] = 1'b1;
    out_ready[1] = 1'b1;
    drain_all();
    $display("random: %0d beats pipelined, %0d beats single-register", sent[0], sent[1]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
